// File: rtl/iir_bp_pkg.sv
// Shared widths, coefficient table and FSM state type for the time-multiplexed
// ECG bandpass IIR (2-48 Hz at fs=500 Hz, four DF1 biquads).
package iir_bp_pkg;

  localparam int unsigned NUM_SOS  = 4;
  localparam int unsigned COEFF_W  = 25;
  localparam int unsigned INOUT_W  = 16;
  localparam int unsigned SCALE    = 23;
  localparam int unsigned ACC_W    = 44;
  localparam int unsigned NUM_TAPS = 5;
  localparam int unsigned SEC_W    = 2;
  localparam int unsigned TAP_W    = 3;
  localparam int unsigned PROD_W   = COEFF_W + INOUT_W;
  localparam int unsigned RES_W    = ACC_W - SCALE;

  typedef logic signed [COEFF_W-1:0] coeff_t;
  typedef logic signed [INOUT_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]   acc_t;

  typedef struct packed {
    coeff_t b0;
    coeff_t b1;
    coeff_t b2;
    coeff_t a1;
    coeff_t a2;
  } sos_coeff_t;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_FIN, ST_OUT} state_t;

  // Coefficients are real value * 2^SCALE.
  function automatic sos_coeff_t sos_coeff(input logic [SEC_W-1:0] sec);
    sos_coeff_t c;
    case (sec)
      SEC_W'(0): c = '{b0: 25'sd2174371, b1: 25'sd0, b2: -25'sd2174371,
                       a1: -25'sd11556035, a2: 25'sd5587438};
      SEC_W'(1): c = '{b0: 25'sd2174371, b1: 25'sd0, b2: -25'sd2174371,
                       a1: -25'sd16621402, a2: 25'sd8238155};
      SEC_W'(2): c = '{b0: 25'sd1949056, b1: 25'sd0, b2: -25'sd1949056,
                       a1: -25'sd16368696, a2: 25'sd7986060};
      default:   c = '{b0: 25'sd1949056, b1: 25'sd0, b2: -25'sd1949056,
                       a1: -25'sd9542824, a2: 25'sd2899653};
    endcase
    return c;
  endfunction

  // Feedback taps are negated here so the MAC only ever adds.
  function automatic coeff_t tap_coeff(input logic [SEC_W-1:0] sec,
                                       input logic [TAP_W-1:0] tap);
    sos_coeff_t c;
    coeff_t     k;
    c = sos_coeff(sec);
    case (tap)
      TAP_W'(0): k = c.b0;
      TAP_W'(1): k = c.b1;
      TAP_W'(2): k = c.b2;
      TAP_W'(3): k = -c.a1;
      default:   k = -c.a2;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// Shared signed 16x25 multiply-accumulate with round-half-up, arithmetic shift
// and 16-bit saturation of the accumulated section result.
module iir_mac_unit
  import iir_bp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic signed [COEFF_W-1:0] coeff,
  input  logic signed [INOUT_W-1:0] data,
  output logic signed [INOUT_W-1:0] y_c,
  output logic                      sat_c
);

  localparam acc_t HALF = acc_t'(2 ** (SCALE - 1));
  localparam logic signed [RES_W-1:0] Y_MAX = RES_W'((2 ** (INOUT_W - 1)) - 1);
  localparam logic signed [RES_W-1:0] Y_MIN = RES_W'(-(2 ** (INOUT_W - 1)));

  acc_t                     acc;
  acc_t                     prod;
  acc_t                     rnd;
  logic signed [PROD_W-1:0] prod_raw;
  logic signed [RES_W-1:0]  res;

  always_comb begin
    prod_raw = PROD_W'(coeff) * PROD_W'(data);
    prod     = ACC_W'(prod_raw);
  end

  // Tap 0 restarts the sum so no separate clear cycle is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clr ? '0 : acc) + prod;
    end
  end

  always_comb begin
    rnd   = acc + HALF;
    res   = RES_W'(rnd >>> SCALE);
    sat_c = 1'b0;
    y_c   = INOUT_W'(res);
    if (res > Y_MAX) begin
      y_c   = INOUT_W'(Y_MAX);
      sat_c = 1'b1;
    end else if (res < Y_MIN) begin
      y_c   = INOUT_W'(Y_MIN);
      sat_c = 1'b1;
    end
  end

endmodule

// File: rtl/iir_sos_cascade_sequencer.sv
// Sequences one shared MAC over four DF1 biquads per sample, holding per-section
// x/y history, with AXI-stream handshakes and full backpressure on both sides.
module iir_sos_cascade_sequencer
  import iir_bp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_axis_tvalid,
  input  logic signed [INOUT_W-1:0] s_axis_tdata,
  output logic                      s_axis_tready,
  output logic signed [INOUT_W-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      sat_pulse
);

  state_t             state;
  logic [SEC_W-1:0]   sec;
  logic [TAP_W-1:0]   tap;
  sample_t            x_cur;
  sample_t            x1 [NUM_SOS];
  sample_t            x2 [NUM_SOS];
  sample_t            y1 [NUM_SOS];
  sample_t            y2 [NUM_SOS];

  coeff_t             mac_coeff_c;
  sample_t            mac_data_c;
  logic               mac_en_c;
  logic               mac_clr_c;
  sample_t            y_c;
  logic               sat_c;

  // Tap mux: pick coefficient and operand for the current section/tap.
  always_comb begin
    mac_coeff_c = tap_coeff(sec, tap);
    case (tap)
      TAP_W'(1): mac_data_c = x1[sec];
      TAP_W'(2): mac_data_c = x2[sec];
      TAP_W'(3): mac_data_c = y1[sec];
      TAP_W'(4): mac_data_c = y2[sec];
      default:   mac_data_c = x_cur;
    endcase
    mac_en_c  = (state == ST_MAC);
    mac_clr_c = (tap == '0);
  end

  iir_mac_unit u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mac_en_c),
    .clr   (mac_clr_c),
    .coeff (mac_coeff_c),
    .data  (mac_data_c),
    .y_c   (y_c),
    .sat_c (sat_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      sec           <= '0;
      tap           <= '0;
      x_cur         <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      sat_pulse     <= 1'b0;
      for (int i = 0; i < NUM_SOS; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      sat_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          s_axis_tready <= 1'b1;
          if (s_axis_tvalid && s_axis_tready) begin
            x_cur         <= s_axis_tdata;
            sec           <= '0;
            tap           <= '0;
            s_axis_tready <= 1'b0;
            state         <= ST_MAC;
          end
        end
        ST_MAC: begin
          tap <= tap + TAP_W'(1);
          if (tap == TAP_W'(NUM_TAPS - 1)) begin
            state <= ST_FIN;
          end
        end
        // Commit the section result; the clamped value feeds both history and next stage.
        ST_FIN: begin
          x2[sec]   <= x1[sec];
          x1[sec]   <= x_cur;
          y2[sec]   <= y1[sec];
          y1[sec]   <= y_c;
          x_cur     <= y_c;
          sat_pulse <= sat_c;
          tap       <= '0;
          if (sec == SEC_W'(NUM_SOS - 1)) begin
            m_axis_tdata  <= y_c;
            m_axis_tvalid <= 1'b1;
            state         <= ST_OUT;
          end else begin
            sec   <= sec + SEC_W'(1);
            state <= ST_MAC;
          end
        end
        ST_OUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_sos_cascade_sequencer.sv
// Randomized bench for the IIR cascade sequencer against a floating-free
// integer model of the four-biquad bandpass, plus pinned impulse values.
module tb_iir_sos_cascade_sequencer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               s_axis_tvalid = 1'b0;
  logic signed [15:0] s_axis_tdata = '0;
  logic               s_axis_tready;
  logic signed [15:0] m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready = 1'b0;
  logic               sat_pulse;

  always #5 clk = ~clk;

  iir_sos_cascade_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .sat_pulse     (sat_pulse)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference filter: direct-form-I difference equation per section.
  longint b0 [4] = '{2174371, 2174371, 1949056, 1949056};
  longint b1 [4] = '{0, 0, 0, 0};
  longint b2 [4] = '{-2174371, -2174371, -1949056, -1949056};
  longint a1 [4] = '{-11556035, -16621402, -16368696, -9542824};
  longint a2 [4] = '{5587438, 8238155, 7986060, 2899653};
  longint mx1 [4];
  longint mx2 [4];
  longint my1 [4];
  longint my2 [4];
  longint stage [4];

  function automatic void model_reset();
    for (int s = 0; s < 4; s++) begin
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
  endfunction

  function automatic void model_step(input longint x_in, output longint y, output int nsat);
    longint x, acc, v;
    x = x_in;
    nsat = 0;
    for (int s = 0; s < 4; s++) begin
      acc = b0[s] * x + b1[s] * mx1[s] + b2[s] * mx2[s] - a1[s] * my1[s] - a2[s] * my2[s];
      v = (acc + 64'sd4194304) >>> 23;
      if (v > 32767) begin v = 32767; nsat++; end
      else if (v < -32768) begin v = -32768; nsat++; end
      mx2[s] = mx1[s]; mx1[s] = x;
      my2[s] = my1[s]; my1[s] = v;
      stage[s] = v;
      x = v;
    end
    y = x;
  endfunction

  task automatic chk(input string name, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  longint           exp_q [$];
  int               exp_sat_q [$];
  longint           got_q [$];
  longint           hs_cyc = -1;
  longint           b2b_prev = -1;
  int               hs_count = 0;
  int               sat_cnt = 0;
  int               sat_total = 0;
  bit               b2b_check = 1'b0;
  bit               cap_stage = 1'b0;
  longint           cap [4];
  bit               prev_tvalid = 1'b0;
  bit               prev_acc = 1'b0;
  logic signed [15:0] prev_tdata = '0;
  int               rdy_mode = 0;

  // Single compare process: handshakes feed the model, accepted outputs are checked.
  always @(negedge clk) begin : mon
    longint y;
    int     ns;
    if (!rst_n) begin
      model_reset();
      exp_q.delete();
      exp_sat_q.delete();
      sat_cnt = 0;
      prev_tvalid = 1'b0;
      prev_acc = 1'b0;
      hs_cyc = -1;
      b2b_prev = -1;
    end else begin
      if (m_axis_tvalid) chk("s_tready_low_while_out", longint'(s_axis_tready), 0);
      if (sat_pulse) begin sat_cnt++; sat_total++; end
      if (m_axis_tvalid && !prev_tvalid) chk("latency", cyc - hs_cyc, 25);
      if (m_axis_tvalid && prev_tvalid && !prev_acc) chk("tdata_stable", m_axis_tdata, prev_tdata);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %0d expected none", m_axis_tdata);
        end else begin
          chk("tdata", m_axis_tdata, exp_q.pop_front());
          chk("sat_count", sat_cnt, exp_sat_q.pop_front());
        end
        got_q.push_back(m_axis_tdata);
        sat_cnt = 0;
      end
      prev_acc = m_axis_tvalid && m_axis_tready;
      prev_tvalid = m_axis_tvalid;
      prev_tdata = m_axis_tdata;
      if (s_axis_tvalid && s_axis_tready) begin
        model_step(s_axis_tdata, y, ns);
        exp_q.push_back(y);
        exp_sat_q.push_back(ns);
        if (cap_stage) begin cap = stage; cap_stage = 1'b0; end
        if (b2b_check && b2b_prev >= 0) chk("b2b_interval", cyc - b2b_prev, 26);
        b2b_prev = cyc;
        hs_cyc = cyc;
        hs_count++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic signed [15:0] x, input bit hold);
    int n = 0;
    bit done = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = x;
    while (!done && n < 2000) begin
      @(negedge clk); n++;
      if (s_axis_tready) begin @(posedge clk); #1; done = 1'b1; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no handshake expected one within 2000 cycles");
    end
    s_axis_tdata = 16'($urandom);
    s_axis_tvalid = hold;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin @(negedge clk); n++; end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    sync();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_s_tready"}, longint'(s_axis_tready), 0);
    chk({tag, "_m_tvalid"}, longint'(m_axis_tvalid), 0);
    chk({tag, "_m_tdata"}, m_axis_tdata, 0);
    chk({tag, "_sat_pulse"}, longint'(sat_pulse), 0);
  endtask

  task automatic wait_ready_after_reset();
    int n = 0;
    do begin @(negedge clk); n++; end while (!s_axis_tready && n < 100);
    chk("tready_after_reset", longint'(s_axis_tready), 1);
    sync();
  endtask

  task automatic impulse_run(input string tag, input bit capture);
    got_q.delete();
    cap_stage = capture;
    send(16'sd16384, 1'b0);
    repeat (11) send(16'sd0, 1'b0);
    wait_drain();
    chk({tag, "_first_out"}, (got_q.size() > 0) ? got_q[0] : -99999, 59);
    chk({tag, "_out_count"}, got_q.size(), 12);
  endtask

  initial begin : main
    int     h0, n, sat0, k;
    longint maxabs;
    rdy_mode = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    wait_ready_after_reset();

    // Impulse: pins both the model's stage values and the DUT output.
    impulse_run("impulse", 1'b1);
    chk("stage0", cap[0], 4247);
    chk("stage1", cap[1], 1101);
    chk("stage2", cap[2], 256);
    chk("stage3", cap[3], 59);

    // DC input must be rejected by the bandpass.
    got_q.delete();
    for (int i = 0; i < 1500; i++) send(16'sd1000, 1'b1);
    s_axis_tvalid = 1'b0;
    wait_drain();
    chk("dc_out_count", got_q.size(), 1500);
    maxabs = 0;
    for (int i = 1300; i < got_q.size(); i++) begin
      if (got_q[i] > maxabs) maxabs = got_q[i];
      if (-got_q[i] > maxabs) maxabs = -got_q[i];
    end
    chk("dc_residual_within_2", longint'(maxabs <= 2), 1);

    // Output stall with a pending input sample.
    rdy_mode = 2;
    send(16'($urandom), 1'b0);
    n = 0;
    while (!m_axis_tvalid && n < 200) begin @(negedge clk); n++; end
    chk("stall_reached_out", longint'(m_axis_tvalid), 1);
    sync();
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'sd1234;
    h0 = hs_count;
    repeat (40) @(negedge clk);
    chk("stall_no_consume", hs_count, h0);
    chk("stall_tvalid_held", longint'(m_axis_tvalid), 1);
    sync();
    rdy_mode = 0;
    send(16'sd1234, 1'b0);
    wait_drain();

    // Full-scale patterns drive sections into saturation.
    rdy_mode = 1;
    sat0 = sat_total;
    for (int i = 0; i < 40; i++) send(((i % 4) < 2) ? 16'sd32767 : -16'sd32768, 1'b0);
    for (int i = 0; i < 120; i++)
      send((((i / 20) % 2) == 0) ? 16'sd32767 : -16'sd32768, 1'($urandom_range(0, 1)));
    s_axis_tvalid = 1'b0;
    wait_drain();
    chk("sat_seen", longint'(sat_total > sat0), 1);

    // Random data, gaps and output backpressure.
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 3);
      if (k > 0) begin repeat (k) @(posedge clk); #1; end
      send(16'($urandom), 1'($urandom_range(0, 1)));
    end
    s_axis_tvalid = 1'b0;
    wait_drain();

    // Back-to-back throughput.
    rdy_mode = 0;
    sync();
    b2b_prev = -1;
    b2b_check = 1'b1;
    for (int i = 0; i < 20; i++) send(16'($urandom), 1'b1);
    s_axis_tvalid = 1'b0;
    wait_drain();
    b2b_check = 1'b0;

    // Reset pulse during section 2 MAC, then the impulse must reproduce.
    send(16'sd16384, 1'b0);
    repeat (13) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("midreset");
    rst_n = 1'b1;
    wait_ready_after_reset();
    impulse_run("impulse_after_reset", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
